tick_scheduler: RTL and testbench

//   Shared timebase scheduler for the display/timer datapath. One prescaler divides clkin to a

---
 rtl/tick_scheduler.sv | 104 ++++++++++
 tb/tb_tick_scheduler.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/tick_scheduler.sv
// Shared timebase scheduler: one prescaler produces a base tick, and NCH channels
// count base ticks and emit periodic or one-shot expiry pulses. Configured via valid/ready.
module tick_scheduler #(
    parameter int unsigned CLK_HZ  = 50000000,
    parameter int unsigned BASE_HZ = 1000,
    parameter int unsigned NCH     = 4,
    parameter int unsigned PW      = 16,
    localparam int unsigned CW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic            clkin,
    input  logic            rst,
    input  logic            run,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic [CW-1:0]   cfg_ch,
    input  logic [PW-1:0]   cfg_period,
    input  logic            cfg_mode,
    input  logic            cfg_en,
    output logic            base_tick,
    output logic [NCH-1:0]  tick,
    output logic [NCH-1:0]  busy
);

    localparam int unsigned PRESCALE = CLK_HZ / BASE_HZ;
    localparam int unsigned PSW      = $clog2(PRESCALE);

    logic [PSW-1:0] r_pre;
    logic           r_base;
    logic           r_ready;
    logic [NCH-1:0] r_tick;
    logic [NCH-1:0] r_armed;
    logic [NCH-1:0] r_mode;
    logic [PW-1:0]  r_cnt [NCH];
    logic [PW-1:0]  r_per [NCH];

    logic           w_pre_last;
    logic           w_wrap;
    logic           w_acc;
    logic           w_wr_hit;
    logic [PSW-1:0] w_pre_nxt;
    logic [NCH-1:0] w_sel;

    // Prescaler wrap and config-write decode.
    always_comb begin
        w_pre_last = (r_pre == PSW'(PRESCALE - 1));
        w_wrap     = run & w_pre_last;
        w_pre_nxt  = w_pre_last ? '0 : r_pre + PSW'(1);
        w_acc      = cfg_valid & r_ready;
        w_wr_hit   = w_acc & (32'(cfg_ch) < NCH);
        w_sel      = '0;
        for (int c = 0; c < NCH; c++) begin
            w_sel[c] = w_wr_hit & (cfg_ch == CW'(c));
        end
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            r_pre   <= '0;
            r_base  <= 1'b0;
            r_ready <= 1'b1;
            r_tick  <= '0;
            r_armed <= '0;
            r_mode  <= '0;
            for (int c = 0; c < NCH; c++) begin
                r_cnt[c] <= '0;
                r_per[c] <= '0;
            end
        end else begin
            if (run) begin
                r_pre <= w_pre_nxt;
            end
            r_base  <= w_wrap;
            r_ready <= ~w_acc;
            for (int c = 0; c < NCH; c++) begin
                r_tick[c] <= 1'b0;
                // A write always wins over an expiry in the same cycle.
                if (w_sel[c]) begin
                    r_per[c]   <= cfg_period;
                    r_mode[c]  <= cfg_mode;
                    r_armed[c] <= cfg_en & (cfg_period != '0);
                    r_cnt[c]   <= '0;
                end else if (r_armed[c]) begin
                    // One-shot disarms one cycle after its tick so busy spans the tick cycle.
                    if (r_tick[c] && r_mode[c]) begin
                        r_armed[c] <= 1'b0;
                    end else if (w_wrap) begin
                        if (r_cnt[c] == r_per[c] - PW'(1)) begin
                            r_tick[c] <= 1'b1;
                            r_cnt[c]  <= '0;
                        end else begin
                            r_cnt[c] <= r_cnt[c] + PW'(1);
                        end
                    end
                end
            end
        end
    end

    assign cfg_ready = r_ready;
    assign base_tick = r_base;
    assign tick      = r_tick;
    assign busy      = r_armed;

endmodule

// File: tb/tb_tick_scheduler.sv
// Scoreboard bench for tick_scheduler: expected base_tick/tick events are queued by the
// stimulus and matched by a monitor whenever the DUT pulses an output.
module tb_tick_scheduler;

    localparam int unsigned NCH = 5;
    localparam int unsigned PW  = 16;
    localparam int unsigned CW  = 3;

    typedef struct {
        int             cyc;
        logic           base;
        logic [NCH-1:0] tk;
    } ev_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           run;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [CW-1:0]  cfg_ch;
    logic [PW-1:0]  cfg_period;
    logic           cfg_mode;
    logic           cfg_en;
    logic           base_tick;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] busy;

    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    ev_t  exp_q[$];
    ev_t  mon_e;

    tick_scheduler #(
        .CLK_HZ (100),
        .BASE_HZ(10),
        .NCH    (NCH),
        .PW     (PW)
    ) dut (
        .clkin     (clk),
        .rst       (rst),
        .run       (run),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_period(cfg_period),
        .cfg_mode  (cfg_mode),
        .cfg_en    (cfg_en),
        .base_tick (base_tick),
        .tick      (tick),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Cycle stamp: 0 on the reset edge, then counts every edge.
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    // Monitor: every output pulse must match the head of the expected-event queue.
    always @(negedge clk) begin
        if (base_tick || (tick != '0)) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL event: unexpected pulse at cyc=%0d base=%0b tick=%b", cyc, base_tick, tick);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.cyc != cyc || mon_e.base != base_tick || mon_e.tk != tick) begin
                    bad++;
                    $display("FAIL event: got cyc=%0d base=%0b tick=%b, want cyc=%0d base=%0b tick=%b",
                             cyc, base_tick, tick, mon_e.cyc, mon_e.base, mon_e.tk);
                end
            end
        end
    end

    task automatic push(input int c, input logic b, input logic [NCH-1:0] t);
        ev_t e;
        e.cyc  = c;
        e.base = b;
        e.tk   = t;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cyc=%0d)", name, act, expv, cyc);
        end
    endtask

    task automatic wait_until(input int n);
        int k;
        k = 0;
        while (cyc != n && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("wait_cycle", cyc, n);
    endtask

    task automatic cfg(input int ch, input int p, input logic mode, input logic en);
        cfg_ch     = CW'(ch);
        cfg_period = PW'(p);
        cfg_mode   = mode;
        cfg_en     = en;
        cfg_valid  = 1'b1;
    endtask

    initial begin
        rst = 1'b1; run = 1'b1; cfg_valid = 1'b0;
        cfg_ch = '0; cfg_period = '0; cfg_mode = 1'b0; cfg_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_base", 32'(base_tick), 0);
        chk("rst_tick", 32'(tick), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(cfg_ready), 1);

        // ch0 P=3 periodic from 13, ch1 P=2 one-shot from 15, run low over edges 76..100.
        push(10, 1'b1, 5'b00000); push(20, 1'b1, 5'b00000); push(30, 1'b1, 5'b00010);
        push(40, 1'b1, 5'b00001); push(50, 1'b1, 5'b00000); push(60, 1'b1, 5'b00000);
        push(70, 1'b1, 5'b00001); push(105, 1'b1, 5'b00000); push(115, 1'b1, 5'b00000);
        push(125, 1'b1, 5'b00001); push(135, 1'b1, 5'b00000); push(145, 1'b1, 5'b00000);
        // Collision at 155 suppresses ch0; ch2 P=1 armed at 164, disabled at 191.
        push(155, 1'b1, 5'b00000); push(165, 1'b1, 5'b00100); push(175, 1'b1, 5'b00100);
        push(185, 1'b1, 5'b00101); push(195, 1'b1, 5'b00000); push(205, 1'b1, 5'b00000);
        push(215, 1'b1, 5'b00001);
        rst = 1'b0;

        wait_until(12); cfg(0, 3, 1'b0, 1'b1);
        wait_until(13); cfg_valid = 1'b0;
        chk("ready_low_after_acc", 32'(cfg_ready), 0);
        wait_until(14); cfg(1, 2, 1'b1, 1'b1);
        chk("ready_high_again", 32'(cfg_ready), 1);
        wait_until(15); cfg_valid = 1'b0;
        wait_until(16); chk("busy_two_armed", 32'(busy), 32'h03);
        wait_until(30); chk("busy_oneshot_tick", 32'(busy), 32'h03);
        wait_until(31); chk("busy_oneshot_fall", 32'(busy), 32'h01);

        wait_until(75);  run = 1'b0;
        wait_until(100); run = 1'b1;

        wait_until(154); cfg(0, 3, 1'b0, 1'b1);
        chk("ready_pat0", 32'(cfg_ready), 1);
        wait_until(155); chk("ready_pat1", 32'(cfg_ready), 0);
        wait_until(156); chk("ready_pat2", 32'(cfg_ready), 1);
        wait_until(157); chk("ready_pat3", 32'(cfg_ready), 0);
        wait_until(158); cfg_valid = 1'b0;
        chk("ready_pat4", 32'(cfg_ready), 1);

        wait_until(160); cfg(5, 1, 1'b0, 1'b1);
        wait_until(161); cfg_valid = 1'b0;
        chk("oor_accepted", 32'(cfg_ready), 0);
        wait_until(162); chk("oor_busy_same", 32'(busy), 32'h01);

        wait_until(163); cfg(2, 1, 1'b0, 1'b1);
        wait_until(164); cfg_valid = 1'b0;
        wait_until(165); chk("busy_ch2_on", 32'(busy), 32'h05);
        wait_until(190); cfg(2, 0, 1'b0, 1'b1);
        wait_until(191); cfg_valid = 1'b0;
        wait_until(192); chk("busy_p0_off", 32'(busy), 32'h01);

        wait_until(218); rst = 1'b1;
        @(negedge clk);
        chk("rst2_base", 32'(base_tick), 0);
        chk("rst2_tick", 32'(tick), 0);
        chk("rst2_busy", 32'(busy), 0);
        chk("rst2_ready", 32'(cfg_ready), 1);
        chk("rst2_cyc", cyc, 0);
        push(10, 1'b1, 5'b00000); push(20, 1'b1, 5'b00000);
        rst = 1'b0;
        wait_until(25);
        chk("events_left", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
